// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// IMEM_LOADER_CHECKSUM_EN adds the trailing checksum state.
package imem_loader_pkg;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        DATA,
        DONE,
        ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        CSUM
`endif
    } state_t;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Little-endian byte-to-word packer; flags the 4th byte of each word.
// The completed word is presented combinationally with that byte.
module word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_done
);

    logic [1:0]  cnt;
    logic [23:0] acc;

    assign word      = {byte_in, acc};
    assign word_done = byte_en && (cnt == 2'(WORD_BYTES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            acc <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (byte_en) begin
            cnt <= cnt + 2'd1;
            acc <= word[31:8];
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: header (word count) then little-endian words into IMEM.
// Optional checksum byte via IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int IMEM_DEPTH      = 1024,
    parameter int IMEM_ADDR_WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       rx_valid,
    input  logic [7:0]                 rx_data,
    output logic                       rx_ready,
    output logic                       imem_we,
    output logic [IMEM_ADDR_WIDTH-1:0] imem_waddr,
    output logic [31:0]                imem_wdata,
    output logic                       cpu_reset_b,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int CW = 17;

    state_t                     state, state_nx;
    logic [15:0]                count_q;
    logic [15:0]                hdr_count;
    logic [IMEM_ADDR_WIDTH-1:0] idx;
    logic [CW-1:0]              idx_nx;
    logic                       xfer, start_ok, byte_en, last_wr;
    logic                       pk_done;
    logic [31:0]                pk_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]                 csum;
`endif

    assign start_ok  = start && (state == IDLE || state == DONE || state == ERR);
    assign xfer      = rx_valid && rx_ready;
    assign byte_en   = xfer && (state == DATA);
    assign hdr_count = {rx_data, count_q[7:0]};
    assign idx_nx    = CW'(idx) + CW'(1);
    assign last_wr   = imem_we && (idx_nx == CW'(count_q));

    assign done        = (state == DONE);
    assign err         = (state == ERR);
    assign cpu_reset_b = (state == DONE);
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign busy = state inside {HDR0, HDR1, DATA, CSUM};
`else
    assign busy = state inside {HDR0, HDR1, DATA};
`endif

    // No byte is taken during a write cycle so words never overlap.
    always_comb begin
        rx_ready = 1'b0;
        unique case (state)
            HDR0, HDR1: rx_ready = 1'b1;
            DATA:       rx_ready = !imem_we;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM:       rx_ready = 1'b1;
`endif
            default:    rx_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, DONE, ERR: if (start) state_nx = HDR0;
            HDR0: if (xfer) state_nx = HDR1;
            HDR1: begin
                if (xfer) begin
                    if (hdr_count == 16'd0)
                        state_nx = DONE;
                    else if (CW'(hdr_count) > CW'(IMEM_DEPTH))
                        state_nx = ERR;
                    else
                        state_nx = DATA;
                end
            end
            DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (last_wr) state_nx = CSUM;
`else
                if (last_wr) state_nx = DONE;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: if (xfer) state_nx = (rx_data == csum) ? DONE : ERR;
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            idx        <= '0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= 1'b0;
            if (start_ok)
                idx <= '0;
            else if (imem_we)
                idx <= idx + 1'b1;
            if (xfer && state == HDR0) count_q[7:0]  <= rx_data;
            if (xfer && state == HDR1) count_q[15:8] <= rx_data;
            if (pk_done) begin
                imem_we    <= 1'b1;
                imem_waddr <= idx;
                imem_wdata <= pk_word;
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        csum <= '0;
        else if (start_ok) csum <= '0;
        else if (byte_en) csum <= csum ^ rx_data;
    end
`endif

    word_packer u_pack (
        .clk       (clk),
        .reset     (reset),
        .clr       (start_ok),
        .byte_en   (byte_en),
        .byte_in   (rx_data),
        .word      (pk_word),
        .word_done (pk_done)
    );

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader; writes are checked as they appear.
// Define IMEM_LOADER_CHECKSUM_EN to exercise the checksum build.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        imem_we;
    logic [9:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        cpu_reset_b, busy, done, err;

    typedef struct {
        logic [9:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] byte_q[$];
    logic [7:0] csum_flip = 8'h00;
    int         total = 0;
    int         bad = 0;
    int         wr_cnt = 0;

    imem_loader #(.IMEM_DEPTH(1024), .IMEM_ADDR_WIDTH(10)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .imem_we     (imem_we),
        .imem_waddr  (imem_waddr),
        .imem_wdata  (imem_wdata),
        .cpu_reset_b (cpu_reset_b),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        wr_t e;
        if (!reset) begin
            total++;
            if (cpu_reset_b !== done) begin
                bad++;
                $display("FAIL crst_vs_done: cpu_reset_b=%b done=%b", cpu_reset_b, done);
            end
            if (imem_we === 1'b1) begin
                wr_cnt++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write: addr=%0d data=%h", imem_waddr, imem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (imem_waddr !== e.a || imem_wdata !== e.d) begin
                        bad++;
                        $display("FAIL write: got addr=%0d data=%h want addr=%0d data=%h",
                                 imem_waddr, imem_wdata, e.a, e.d);
                    end
                end
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int n = 0;
        if (rnd) begin
            while ($urandom_range(0, 1) == 1) begin
                rx_valid = 1'b0;
                @(negedge clk);
            end
        end
        rx_valid = 1'b1;
        rx_data  = b;
        while (rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL rx_ready_timeout: rx_ready=%b want 1", rx_ready);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic load(input bit rnd);
        logic [15:0] n;
        logic [31:0] w;
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0]  x = 8'h00;
`endif
        n = 16'(byte_q.size() / 4);
        w = '0;
        pulse_start();
        send_byte(n[7:0], rnd);
        send_byte(n[15:8], rnd);
        for (int i = 0; i < byte_q.size(); i++) begin
            w = {byte_q[i], w[31:8]};
`ifdef IMEM_LOADER_CHECKSUM_EN
            x = x ^ byte_q[i];
`endif
            if (i % 4 == 3) exp_q.push_back('{a: 10'(i / 4), d: w});
            send_byte(byte_q[i], rnd);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(x ^ csum_flip, rnd);
`endif
    endtask

    task automatic wait_end();
        int n = 0;
        while (done !== 1'b1 && err !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL end_timeout: done=%b err=%b want one set", done, err);
        end
    endtask

    task automatic check_ok(input string tag);
        total++;
        if (done !== 1'b1 || err !== 1'b0 || cpu_reset_b !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_end: done=%b err=%b crst=%b busy=%b want 1 0 1 0",
                     tag, done, err, cpu_reset_b, busy);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_missing: pending=%0d want 0", tag, exp_q.size());
        end
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (rx_ready !== 1'b0 || imem_we !== 1'b0 || imem_waddr !== 10'd0 ||
            imem_wdata !== 32'd0) begin
            bad++;
            $display("FAIL reset_data: rdy=%b we=%b addr=%0d data=%h want 0",
                     rx_ready, imem_we, imem_waddr, imem_wdata);
        end
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || cpu_reset_b !== 1'b0) begin
            bad++;
            $display("FAIL reset_status: busy=%b done=%b err=%b crst=%b want 0",
                     busy, done, err, cpu_reset_b);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] b[8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        pulse_start();
        total++;
        if (busy !== 1'b1 || rx_ready !== 1'b1 || cpu_reset_b !== 1'b0) begin
            bad++;
            $display("FAIL basic_hdr0: busy=%b rdy=%b crst=%b want 1 1 0",
                     busy, rx_ready, cpu_reset_b);
        end
        send_byte(8'h02, 1'b0);
        pulse_start();
        send_byte(8'h00, 1'b0);
        total++;
        if (busy !== 1'b1 || rx_ready !== 1'b1) begin
            bad++;
            $display("FAIL basic_data: busy=%b rdy=%b want 1 1", busy, rx_ready);
        end
        exp_q.push_back('{a: 10'd0, d: 32'h0000_0013});
        exp_q.push_back('{a: 10'd1, d: 32'h0010_0093});
        for (int i = 0; i < 8; i++) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            byte_q.push_back(b[i]);
`endif
            send_byte(b[i], 1'b0);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h13 ^ 8'h93 ^ 8'h10, 1'b0);
        byte_q.delete();
`endif
        wait_end();
        check_ok("basic");
    endtask

    task automatic test_reload_zero();
        int w0 = wr_cnt;
        pulse_start();
        total++;
        if (cpu_reset_b !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL reload_reset: crst=%b done=%b busy=%b want 0 0 1",
                     cpu_reset_b, done, busy);
        end
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        total++;
        if (done !== 1'b1 || cpu_reset_b !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_done: done=%b crst=%b busy=%b want 1 1 0",
                     done, cpu_reset_b, busy);
        end
        repeat (3) @(negedge clk);
        total++;
        if (wr_cnt != w0) begin
            bad++;
            $display("FAIL zero_writes: got %0d want 0", wr_cnt - w0);
        end
    endtask

    task automatic test_overflow();
        int w0 = wr_cnt;
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h04, 1'b0);
        total++;
        if (err !== 1'b1 || done !== 1'b0 || rx_ready !== 1'b0 || cpu_reset_b !== 1'b0) begin
            bad++;
            $display("FAIL ovf_err: err=%b done=%b rdy=%b crst=%b want 1 0 0 0",
                     err, done, rx_ready, cpu_reset_b);
        end
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        repeat (4) @(negedge clk);
        rx_valid = 1'b0;
        total++;
        if (err !== 1'b1 || busy !== 1'b0 || wr_cnt != w0) begin
            bad++;
            $display("FAIL ovf_ignore: err=%b busy=%b writes=%0d want 1 0 0",
                     err, busy, wr_cnt - w0);
        end
    endtask

    task automatic test_reset_mid();
        int w0;
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hde, 1'b0);
        send_byte(8'had, 1'b0);
        w0 = wr_cnt;
        #2 reset = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || rx_ready !== 1'b0 || imem_we !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: busy=%b rdy=%b we=%b err=%b want 0",
                     busy, rx_ready, imem_we, err);
        end
        @(negedge clk);
        reset = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'hbe;
        repeat (4) @(negedge clk);
        rx_valid = 1'b0;
        total++;
        if (wr_cnt != w0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_nowrite: writes=%0d busy=%b want 0 0", wr_cnt - w0, busy);
        end
        byte_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        load(1'b0);
        wait_end();
        check_ok("restart");
    endtask

    task automatic test_full();
        int w0 = wr_cnt;
        byte_q.delete();
        for (int i = 0; i < 4096; i++) byte_q.push_back(8'($urandom_range(0, 255)));
        load(1'b1);
        wait_end();
        check_ok("full");
        total++;
        if (wr_cnt - w0 != 1024) begin
            bad++;
            $display("FAIL full_count: got %0d want 1024", wr_cnt - w0);
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_csum();
        byte_q = '{8'haa, 8'hbb, 8'hcc, 8'hdd};
        csum_flip = 8'h00;
        load(1'b0);
        wait_end();
        check_ok("csum_ok");
        csum_flip = 8'h01;
        load(1'b0);
        wait_end();
        total++;
        if (err !== 1'b1 || done !== 1'b0 || cpu_reset_b !== 1'b0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL csum_bad: err=%b done=%b crst=%b pending=%0d want 1 0 0 0",
                     err, done, cpu_reset_b, exp_q.size());
        end
        csum_flip = 8'h00;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_reload_zero();
        test_overflow();
        test_reset_mid();
        test_full();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_csum();
`endif
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
